// File: rtl/sp_stack_ctrl.sv
// rtl/sp_stack_ctrl.sv - stack pointer register, SP_ALU control encoding and stack RAM
module sp_stack_ctrl #(
    parameter int DATA_W = 16,
    parameter int SP_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_req,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic [SP_W-1:0]   sp,
    output logic              sp_sel,
    output logic              sp_sel1,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err,
    input  logic              err_clr
);

    localparam int DEPTH = 2 ** SP_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              full_q;
    logic              pop_acc;
    logic              push_acc;
    logic              push_only;
    logic              pop_only;
    logic              both_acc;
    logic [SP_W-1:0]   sp_inc;
    logic [SP_W-1:0]   sp_dec;
    logic              ovf_set;
    logic              unf_set;

    // Status, acceptance and SP arithmetic; next-SP wraps naturally in SP_W bits
    always_comb begin
        empty      = (sp == '0) && !full_q;
        full       = full_q;
        pop_acc    = pop_req && !empty;
        push_ready = !full_q || pop_acc;
        push_acc   = push_valid && push_ready;
        push_only  = push_acc && !pop_acc;
        pop_only   = pop_acc && !push_acc;
        both_acc   = push_acc && pop_acc;
        sp_inc     = sp + 1'b1;
        sp_dec     = sp - 1'b1;
        ovf_set    = push_valid && full_q && !pop_acc;
        unf_set    = pop_req && empty;
    end

    // SP_ALU control: decrement on pop-only, increment on push-only, otherwise hold
    always_comb begin
        sp_sel  = 1'b0;
        sp_sel1 = 1'b1;
        if (!flush) begin
            if (pop_only) begin
                sp_sel  = 1'b1;
                sp_sel1 = 1'b0;
            end else if (push_only) begin
                sp_sel  = 1'b0;
                sp_sel1 = 1'b0;
            end
        end
    end

    // Stack RAM writes; not reset, suppressed during flush
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_only) begin
                mem[sp] <= push_data;
            end else if (both_acc) begin
                mem[sp_dec] <= push_data;
            end
        end
    end

    // SP, full flag and popped-data register; RAM read sees the pre-write contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            full_q    <= 1'b0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else if (flush) begin
            sp        <= '0;
            full_q    <= 1'b0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= pop_acc;
            if (pop_acc) begin
                pop_data <= mem[sp_dec];
            end
            if (push_only) begin
                sp <= sp_inc;
                if (sp == SP_W'(DEPTH - 1)) begin
                    full_q <= 1'b1;
                end
            end else if (pop_only) begin
                sp     <= sp_dec;
                full_q <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
            if (unf_set) begin
                unf_err <= 1'b1;
            end else if (err_clr) begin
                unf_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sp_stack_ctrl.md
Name: sp_stack_ctrl

Overview:
- Stack-pointer register and hardware stack memory for the CPU's call/operand stack.
- Registers the 5-bit SP, computes the next SP with the team's SP_ALU encoding (decrement / hold / increment), and owns the stack RAM.
- Sits upstream of the SP_ALU path and feeds the pipeline's stack-access stage with the popped data.

Parameters:
- DATA_W, 16, width of one stack entry.
- SP_W, 5, SP width; DEPTH = 2**SP_W entries (32).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous stack clear.
- push_valid  in  1  push request.
- push_data  in  DATA_W  value to push.
- push_ready  out  1  push accepted this cycle (combinational).
- pop_req  in  1  pop request.
- pop_valid  out  1  registered; popped data valid.
- pop_data  out  DATA_W  registered popped value.
- sp  out  SP_W  current stack pointer; points to the next free slot.
- sp_sel  out  1  SP_ALU-encoded control, decrement this cycle.
- sp_sel1  out  1  SP_ALU-encoded control, hold this cycle.
- full  out  1  DEPTH entries held.
- empty  out  1  no entries held.
- ovf_err  out  1  sticky; push attempted while full without a concurrent pop.
- unf_err  out  1  sticky; pop attempted while empty.
- err_clr  in  1  clears both sticky errors.

Behaviour:
- Reset (rst_n low, asynchronous): sp=0, full_q=0, pop_valid=0, pop_data=0, ovf_err=0, unf_err=0. RAM contents are not reset.
- Status flags:
  - empty = (sp==0) && !full_q.
  - full = full_q.
- Acceptance:
  - pop_acc = pop_req && !empty.
  - push_ready = !full || pop_acc.
  - push_acc = push_valid && push_ready.
- Operations, per cycle, when flush is low:
  - Push only: mem[sp] <= push_data; sp <= sp+1, mod 2**SP_W. If sp was DEPTH-1, sp wraps to 0 and full_q <= 1. SP_ALU controls: sp_sel=0, sp_sel1=0.
  - Pop only: pop_data <= mem[sp-1]; sp <= sp-1, mod 2**SP_W; full_q <= 0. When full, sp=0 wraps to DEPTH-1. SP_ALU controls: sp_sel=1.
  - Push and pop both accepted (replace-top): pop_data <= old mem[sp-1]; mem[sp-1] <= push_data. sp and full_q are unchanged. SP_ALU controls: sp_sel=0, sp_sel1=1.
  - Neither accepted: hold. SP_ALU controls: sp_sel=0, sp_sel1=1.
- Empty with push and pop both requested: pop is rejected and unf_err sets; the push executes normally.
- pop_valid <= pop_acc. It is high for exactly one cycle per accepted pop, one cycle after the request. pop_data holds its value otherwise.
- RAM read is read-before-write for the same address in the same cycle.
- ovf_err sets on push_valid && full && !pop_acc. That push is dropped.
- unf_err sets on pop_req && empty. No pop_valid is produced.
- err_clr clears both errors. A set condition in the same cycle wins over err_clr.
- flush has highest priority:
  - Next cycle: sp=0, full_q=0, pop_valid=0.
  - No RAM write; push_ready is still computed but the push is discarded.
  - Errors are unaffected.
- Asserting rst_n low mid-operation immediately returns all outputs to their reset values. Partially completed operations are lost.
- The next-SP arithmetic is exactly SP_W bits with natural wrap. The wrap is legal only via the full_q mechanism; sp itself never exceeds DEPTH-1.

Test Plan:
- Reset then 3 pushes (0x1111, 0x2222, 0x3333) -> sp=3, empty=0; 3 pops -> pop_data 0x3333, 0x2222, 0x1111 each one cycle after pop_req, then sp=0, empty=1.
- Fill stack with 32 pushes of values 0..31 -> after the last push sp=0, full=1, push_ready=0; a 33rd push sets ovf_err=1 with sp/full unchanged; one pop returns 31, sp=31, full=0.
- Pop from empty -> unf_err=1, pop_valid stays 0; err_clr -> unf_err=0; pop while err_clr high and still empty -> unf_err=1.
- Stack holding 5 entries, top 0x00AA; simultaneous push 0xBBBB and pop -> pop_data=0x00AA, sp unchanged at 5; next pop returns 0xBBBB.
- Full stack with simultaneous push and pop -> push_ready=1, replace-top occurs, full stays 1, no ovf_err.
- Push 4 entries, then flush concurrent with pop_req -> next cycle sp=0, empty=1, pop_valid=0. Separately, assert rst_n low mid-push burst -> all outputs reset immediately, without waiting for a clock edge.
